// File: rtl/mul_unit_if.sv
// rtl/mul_unit_if.sv - request/writeback bundle between the core and the multiply unit
interface mul_unit_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             START;
    logic [WIDTH-1:0] OP_A;
    logic [WIDTH-1:0] OP_B;
    logic [WIDTH-1:0] ACC;
    logic             ACCUMULATE;
    logic             SET_FLAGS;
    logic [AW-1:0]    DEST;
    logic             BUSY;
    logic             WE3;
    logic [AW-1:0]    A3;
    logic [WIDTH-1:0] WD3;
    logic             FLAG_WE;
    logic             N_FLAG;
    logic             Z_FLAG;

    modport master (
        output START, OP_A, OP_B, ACC, ACCUMULATE, SET_FLAGS, DEST,
        input  BUSY, WE3, A3, WD3, FLAG_WE, N_FLAG, Z_FLAG
    );

    modport slave (
        input  START, OP_A, OP_B, ACC, ACCUMULATE, SET_FLAGS, DEST,
        output BUSY, WE3, A3, WD3, FLAG_WE, N_FLAG, Z_FLAG
    );
endinterface

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - iterative shift-add MUL/MLA unit with early termination
module mul_unit #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic     CLK,
    input  logic     RST_N,
    mul_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplr_q;
    logic [WIDTH-1:0] prod_q;
    logic [AW-1:0]    dest_q;
    logic             sflag_q;

    logic [WIDTH-1:0] prod_sum;
    logic [WIDTH-1:0] mplr_shift;
    logic             run_done;

    logic             we3_q;
    logic             flag_we_q;
    logic [AW-1:0]    a3_q;
    logic [WIDTH-1:0] wd3_q;
    logic             n_q;
    logic             z_q;

    // One radix-2 step: conditional add, and detect that no multiplier bits remain
    always_comb begin
        prod_sum   = mplr_q[0] ? (prod_q + mcand_q) : prod_q;
        mplr_shift = mplr_q >> 1;
        run_done   = (mplr_shift == '0);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.START) state_d = S_RUN;
            S_RUN:   if (run_done)  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Operand capture in IDLE and shift-add iteration in RUN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            prod_q  <= '0;
            dest_q  <= '0;
            sflag_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        mcand_q <= bus.OP_A;
                        mplr_q  <= bus.OP_B;
                        prod_q  <= bus.ACCUMULATE ? bus.ACC : '0;
                        dest_q  <= bus.DEST;
                        sflag_q <= bus.SET_FLAGS;
                    end
                end
                S_RUN: begin
                    prod_q  <= prod_sum;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_shift;
                end
                default: ;
            endcase
        end
    end

    // Writeback registers: loaded from the final step so they are valid exactly during WB
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            we3_q     <= 1'b0;
            flag_we_q <= 1'b0;
            a3_q      <= '0;
            wd3_q     <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b1;
        end else begin
            we3_q     <= 1'b0;
            flag_we_q <= 1'b0;
            if (state_q == S_RUN && run_done) begin
                we3_q     <= 1'b1;
                flag_we_q <= sflag_q;
                a3_q      <= dest_q;
                wd3_q     <= prod_sum;
                n_q       <= prod_sum[WIDTH-1];
                z_q       <= (prod_sum == '0);
            end
        end
    end

    assign bus.BUSY    = (state_q != S_IDLE);
    assign bus.WE3     = we3_q;
    assign bus.FLAG_WE = flag_we_q;
    assign bus.A3      = a3_q;
    assign bus.WD3     = wd3_q;
    assign bus.N_FLAG  = n_q;
    assign bus.Z_FLAG  = z_q;
endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - randomized self-checking bench for mul_unit against an arithmetic model
module tb_mul_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mul_unit_if #(.WIDTH(32), .AW(4)) bus ();

    mul_unit #(.WIDTH(32), .AW(4)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_cycles(input logic [31:0] b);
        int k;
        k = 1;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] acc, input logic accum);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b} + (accum ? {32'd0, acc} : 64'd0);
        return full[31:0];
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                            input logic accum, input logic sf, input logic [3:0] dest);
        bus.OP_A       = a;
        bus.OP_B       = b;
        bus.ACC        = acc;
        bus.ACCUMULATE = accum;
        bus.SET_FLAGS  = sf;
        bus.DEST       = dest;
        bus.START      = 1'b1;
        @(posedge clk);
        #1;
        bus.START      = 1'b0;
    endtask

    task automatic wait_wb(input string tag, input int exp_edges, input logic [31:0] exp_wd,
                           input logic [3:0] exp_dest, input logic exp_fwe);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (bus.WE3) seen = 1;
        end
        chk({tag, "_we3_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_latency"}, 64'(n), 64'(exp_edges));
            chk({tag, "_busy_wb"}, 64'(bus.BUSY), 64'd1);
            chk({tag, "_a3"}, 64'(bus.A3), 64'(exp_dest));
            chk({tag, "_wd3"}, 64'(bus.WD3), 64'(exp_wd));
            chk({tag, "_flag_we"}, 64'(bus.FLAG_WE), 64'(exp_fwe));
            chk({tag, "_n"}, 64'(bus.N_FLAG), 64'(exp_wd[31]));
            chk({tag, "_z"}, 64'(bus.Z_FLAG), 64'(exp_wd == 32'd0));
            @(posedge clk);
            #1;
            chk({tag, "_we3_off"}, 64'(bus.WE3), 64'd0);
            chk({tag, "_fwe_off"}, 64'(bus.FLAG_WE), 64'd0);
            chk({tag, "_busy_off"}, 64'(bus.BUSY), 64'd0);
            chk({tag, "_wd3_hold"}, 64'(bus.WD3), 64'(exp_wd));
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] acc, input logic accum, input logic sf,
                          input logic [3:0] dest);
        start_op(a, b, acc, accum, sf, dest);
        wait_wb(tag, ref_cycles(b), ref_result(a, b, acc, accum), dest, sf);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb, racc;
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.START      = 1'b0;
        bus.OP_A       = 32'hDEAD_BEEF;
        bus.OP_B       = 32'h0000_00FF;
        bus.ACC        = 32'd0;
        bus.ACCUMULATE = 1'b0;
        bus.SET_FLAGS  = 1'b0;
        bus.DEST       = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.BUSY), 64'd0);
        chk("rst_we3", 64'(bus.WE3), 64'd0);
        chk("rst_fwe", 64'(bus.FLAG_WE), 64'd0);
        chk("rst_a3", 64'(bus.A3), 64'd0);
        chk("rst_wd3", 64'(bus.WD3), 64'd0);
        chk("rst_n", 64'(bus.N_FLAG), 64'd0);
        chk("rst_z", 64'(bus.Z_FLAG), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul6x7", 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 4'd3);
        run_op("mla_wrap", 32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b0, 4'd7);
        run_op("mul_msb", 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 4'd1);
        run_op("mla_b0", 32'h0000_1234, 32'd0, 32'd9, 1'b1, 1'b1, 4'd2);
        run_op("mul_neg", 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 4'd15);

        start_op(32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 4'd4);
        bus.START = 1'b1;
        bus.OP_A  = 32'd100;
        bus.OP_B  = 32'd3;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        bus.OP_A  = $urandom;
        bus.OP_B  = $urandom;
        wait_wb("ignore_start", 2, 32'd42, 4'd4, 1'b1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.WE3 || bus.BUSY) pulses++;
        end
        chk("ignore_start_extra", 64'(pulses), 64'd0);

        start_op(32'h10, 32'h100, 32'd0, 1'b0, 1'b1, 4'd5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy", 64'(bus.BUSY), 64'd0);
        chk("abort_we3", 64'(bus.WE3), 64'd0);
        chk("abort_wd3", 64'(bus.WD3), 64'd0);
        chk("abort_z", 64'(bus.Z_FLAG), 64'd1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.WE3 || bus.FLAG_WE) pulses++;
        end
        chk("abort_no_wb", 64'(pulses), 64'd0);
        run_op("after_abort", 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'd6);

        for (int t = 0; t < 25; t++) begin
            ra   = $urandom;
            rb   = $urandom >> $urandom_range(0, 31);
            racc = $urandom;
            run_op($sformatf("rnd%0d", t), ra, rb, racc, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative multiply/multiply-accumulate execution unit for MUL/MLA.
- Operands come from the register-file read ports (RD1, RD2, plus an accumulate operand); the result goes back through the register-file write port (A3/WD3/WE3).
- Uses radix-2 shift-add with early termination. The core stalls fetch/issue while BUSY is high.

Parameters:
- WIDTH, 32, operand/result width in bits
- AW, 4, register address width (16 architectural registers)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  synchronous active-low reset
- START  input  1  request; sampled only in IDLE
- OP_A  input  WIDTH  multiplicand (Rm)
- OP_B  input  WIDTH  multiplier (Rs)
- ACC  input  WIDTH  accumulate operand (Rn); ignored unless ACCUMULATE=1
- ACCUMULATE  input  1  1=MLA, 0=MUL
- SET_FLAGS  input  1  S bit; request N/Z update
- DEST  input  AW  destination register index
- BUSY  output  1  high in RUN and WB
- WE3  output  1  register-file write enable, one-cycle pulse
- A3  output  AW  write address
- WD3  output  WIDTH  write data (low WIDTH bits of result)
- FLAG_WE  output  1  flag write enable, coincident with WE3
- N_FLAG  output  1  WD3[WIDTH-1]
- Z_FLAG  output  1  WD3==0

Behaviour:
- Reset (RST_N=0 at a rising edge): state=IDLE.
  - BUSY=0, WE3=0, FLAG_WE=0, A3=0, WD3=0, N_FLAG=0, Z_FLAG=1.
  - Internal mcand/mplr/prod registers are cleared.
- Reset mid-operation aborts the operation: no WE3 pulse, no flag write, return to IDLE next cycle.
- States: IDLE, RUN, WB.
- IDLE:
  - On START=1, latch the following and go to RUN:
    - mcand=OP_A, mplr=OP_B
    - prod = ACCUMULATE ? ACC : 0
    - dest=DEST, sflag=SET_FLAGS
  - START=0 stays IDLE.
  - Operands are only needed in the START cycle.
- RUN, each cycle:
  - if mplr[0], prod += mcand, modulo 2^WIDTH;
  - mcand <<= 1 (bits shifted out discarded);
  - mplr >>= 1 (logical).
  - If the shifted mplr is 0, go to WB; otherwise stay in RUN.
  - RUN lasts k = max(1, msb_index(OP_B)+1) cycles. OP_B=0 gives k=1; OP_B[31]=1 gives k=32.
- WB (exactly one cycle):
  - WE3=1, A3=dest, WD3=prod.
  - FLAG_WE=sflag, N_FLAG=prod[WIDTH-1], Z_FLAG=(prod==0).
  - Next state is IDLE.
- Outputs are registered. WE3/FLAG_WE are high only during WB. A3/WD3/N/Z hold their last WB values outside WB.
- Latency: START sampled at edge E0. WE3 is high during the cycle following E0+k edges, i.e. k+1 cycles after E0. Total occupancy is k+1 cycles; a new START is accepted in the first IDLE cycle after WB.
- START while BUSY=1 is ignored; no queueing, latched operands are unaffected.
- Arithmetic is unsigned and truncated to the low WIDTH bits. Signed two's-complement inputs give the correct low-word result. No carry or overflow flags are produced.
- Operand changes on the inputs during RUN/WB have no effect.

Test Plan:
- MUL, OP_A=6, OP_B=7, DEST=3, SET_FLAGS=1 -> 3 RUN cycles; WE3 pulse 4 cycles after START edge with A3=3, WD3=42, FLAG_WE=1, N=0, Z=0; BUSY low the next cycle.
- MLA, OP_A=0xFFFFFFFF, OP_B=2, ACC=5, DEST=7 -> 2 RUN cycles; WD3=0x00000003 (wrap); FLAG_WE=0 since SET_FLAGS=0.
- MUL, OP_A=0x80000000, OP_B=0x80000000, SET_FLAGS=1 -> 32 RUN cycles; WE3 at cycle 33; WD3=0, Z=1, N=0.
- MLA, OP_B=0, ACC=9, OP_A=0x1234 -> 1 RUN cycle; WD3=9, WE3 at cycle 2. Then MUL, OP_A=0xFFFFFFFF, OP_B=1, SET_FLAGS=1 -> WD3=0xFFFFFFFF, N=1.
- Start 6*7, then pulse START with OP_A=100 and change OP_A/OP_B during RUN -> result still 42; exactly one WE3 pulse; the second START is ignored.
- Start 0x10*0x100, assert RST_N=0 for one cycle during the 3rd RUN cycle -> no WE3/FLAG_WE pulse; BUSY=0, WD3=0, Z_FLAG=1 after reset; a following START 3*5 yields WD3=15.
